// File: rtl/cva6_lsu_queue_model.sv
// Control model of the CVA6 LSU: a single-outstanding load FSM in front of a
// two-stage (speculative -> commit) store buffer, tracking only address page offsets.
module cva6_lsu_queue_model (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] instr_i,
    input  logic        is_load_i,
    input  logic        instr_valid_i,
    input  logic        store_commit_i,
    input  logic        store_mem_resp_i,
    input  logic        load_mem_resp_i,
    output logic        load_req_o,
    output logic        ready_o,
    output logic [7:0]  store_state_o,
    output logic [1:0]  load_state_o
);
    typedef enum logic [1:0] {
        LD_IDLE    = 2'd0,
        LD_WAIT    = 2'd1,
        LD_BLOCKED = 2'd2
    } ld_state_e;

    // Only addr[11:3] ever takes part in a decision, so only that field is stored.
    logic [8:0] spec_addr_q [4];
    logic [8:0] spec_addr_d [4];
    logic [8:0] cmt_addr_q  [4];
    logic [8:0] cmt_addr_d  [4];
    logic [1:0] spec_head_q, spec_head_d, spec_tail_q, spec_tail_d;
    logic [1:0] cmt_head_q, cmt_head_d, cmt_tail_q, cmt_tail_d;
    logic [2:0] spec_cnt_q, spec_cnt_d, cmt_cnt_q, cmt_cnt_d;
    logic [8:0] load_off_q, load_off_d;
    ld_state_e  state_q, state_d;

    logic [8:0] instr_off;
    logic       unused_instr_bits;
    logic [3:0] spec_valid, cmt_valid;
    logic [3:0] spec_hit_new, cmt_hit_new, spec_hit_ld, cmt_hit_ld;
    logic       hazard_new, hazard_ld;
    logic       push, load_acc, do_commit, do_retire;

    assign instr_off         = instr_i[11:3];
    assign unused_instr_bits = ^{instr_i[31:12], instr_i[2:0]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_entry
        logic [1:0] spec_off;
        logic [1:0] cmt_off;
        // Entry is live when its distance from the head is below the occupancy.
        assign spec_off          = 2'(gi) - spec_head_q;
        assign cmt_off           = 2'(gi) - cmt_head_q;
        assign spec_valid[gi]    = {1'b0, spec_off} < spec_cnt_q;
        assign cmt_valid[gi]     = {1'b0, cmt_off} < cmt_cnt_q;
        assign spec_hit_new[gi]  = spec_valid[gi] && (spec_addr_q[gi] == instr_off);
        assign cmt_hit_new[gi]   = cmt_valid[gi] && (cmt_addr_q[gi] == instr_off);
        assign spec_hit_ld[gi]   = spec_valid[gi] && (spec_addr_q[gi] == load_off_q);
        assign cmt_hit_ld[gi]    = cmt_valid[gi] && (cmt_addr_q[gi] == load_off_q);
        assign store_state_o[gi]     = spec_cnt_q > 3'(gi);
        assign store_state_o[gi + 4] = cmt_cnt_q > 3'(gi);
    end

    assign hazard_new   = |{spec_hit_new, cmt_hit_new};
    assign hazard_ld    = |{spec_hit_ld, cmt_hit_ld};
    assign ready_o      = (state_q == LD_IDLE) && (spec_cnt_q < 3'd4);
    assign load_req_o   = (state_q == LD_WAIT);
    assign load_state_o = state_q;

    assign push      = instr_valid_i && ready_o && !is_load_i;
    assign load_acc  = instr_valid_i && ready_o && is_load_i;
    assign do_commit = store_commit_i && (spec_cnt_q != 3'd0) && (cmt_cnt_q != 3'd4);
    assign do_retire = store_mem_resp_i && (cmt_cnt_q != 3'd0);

    always_comb begin
        spec_addr_d = spec_addr_q;
        cmt_addr_d  = cmt_addr_q;
        spec_head_d = spec_head_q;
        spec_tail_d = spec_tail_q;
        cmt_head_d  = cmt_head_q;
        cmt_tail_d  = cmt_tail_q;
        if (push) begin
            spec_addr_d[spec_tail_q] = instr_off;
            spec_tail_d              = spec_tail_q + 2'd1;
        end
        if (do_commit) begin
            cmt_addr_d[cmt_tail_q] = spec_addr_q[spec_head_q];
            cmt_tail_d             = cmt_tail_q + 2'd1;
            spec_head_d            = spec_head_q + 2'd1;
        end
        if (do_retire) begin
            cmt_head_d = cmt_head_q + 2'd1;
        end
        spec_cnt_d = spec_cnt_q + {2'b00, push} - {2'b00, do_commit};
        cmt_cnt_d  = cmt_cnt_q + {2'b00, do_commit} - {2'b00, do_retire};
    end

    always_comb begin
        state_d    = state_q;
        load_off_d = load_off_q;
        case (state_q)
            LD_IDLE: begin
                if (load_acc) begin
                    load_off_d = instr_off;
                    state_d    = hazard_new ? LD_BLOCKED : LD_WAIT;
                end
            end
            LD_WAIT: begin
                if (load_mem_resp_i) state_d = LD_IDLE;
            end
            LD_BLOCKED: begin
                if (!hazard_ld) state_d = LD_WAIT;
            end
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            for (int i = 0; i < 4; i++) begin
                spec_addr_q[i] <= '0;
                cmt_addr_q[i]  <= '0;
            end
            spec_head_q <= '0;
            spec_tail_q <= '0;
            cmt_head_q  <= '0;
            cmt_tail_q  <= '0;
            spec_cnt_q  <= '0;
            cmt_cnt_q   <= '0;
            load_off_q  <= '0;
            state_q     <= LD_IDLE;
        end else begin
            spec_addr_q <= spec_addr_d;
            cmt_addr_q  <= cmt_addr_d;
            spec_head_q <= spec_head_d;
            spec_tail_q <= spec_tail_d;
            cmt_head_q  <= cmt_head_d;
            cmt_tail_q  <= cmt_tail_d;
            spec_cnt_q  <= spec_cnt_d;
            cmt_cnt_q   <= cmt_cnt_d;
            load_off_q  <= load_off_d;
            state_q     <= state_d;
        end
    end
endmodule

// File: tb/tb_cva6_lsu_queue_model.sv
// Scoreboard bench for cva6_lsu_queue_model: a queue-based reference model predicts the
// outputs after every edge; a monitor compares them against the DUT.
module tb_cva6_lsu_queue_model;
    logic        clk = 1'b0;
    logic        rst, valid, is_load, commit, smr, lmr;
    logic [31:0] addr;
    logic        load_req, ready;
    logic [7:0]  store_state;
    logic [1:0]  load_state;

    typedef struct packed {
        logic       ready;
        logic       req;
        logic [7:0] st;
        logic [1:0] ld;
    } obs_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_edge = 0;
    obs_t        exp_q[$];
    logic [31:0] m_spec[$];
    logic [31:0] m_cmt[$];
    logic [31:0] m_load_addr;
    int          m_ld;

    always #5 clk = ~clk;

    cva6_lsu_queue_model dut (
        .clk_i            (clk),
        .rst_ni           (rst),
        .instr_i          (addr),
        .is_load_i        (is_load),
        .instr_valid_i    (valid),
        .store_commit_i   (commit),
        .store_mem_resp_i (smr),
        .load_mem_resp_i  (lmr),
        .load_req_o       (load_req),
        .ready_o          (ready),
        .store_state_o    (store_state),
        .load_state_o     (load_state)
    );

    function automatic bit m_hit(logic [31:0] a);
        foreach (m_spec[i]) if (m_spec[i][11:3] == a[11:3]) return 1'b1;
        foreach (m_cmt[i])  if (m_cmt[i][11:3] == a[11:3]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic obs_t m_obs();
        obs_t r;
        r.ready = (m_ld == 0) && (m_spec.size() < 4);
        r.req   = (m_ld == 1);
        for (int i = 0; i < 4; i++) begin
            r.st[i]     = m_spec.size() > i;
            r.st[i + 4] = m_cmt.size() > i;
        end
        r.ld = 2'(m_ld);
        return r;
    endfunction

    function automatic obs_t dut_obs();
        obs_t r;
        r.ready = ready;
        r.req   = load_req;
        r.st    = store_state;
        r.ld    = load_state;
        return r;
    endfunction

    task automatic m_step(input logic r_, v_, l_, input logic [31:0] a_, input logic c_, s_, lm_);
        bit rdy, push, lacc, com, ret;
        int nxt;
        if (r_) begin
            m_spec.delete();
            m_cmt.delete();
            m_ld = 0;
            m_load_addr = '0;
            return;
        end
        rdy  = (m_ld == 0) && (m_spec.size() < 4);
        push = v_ && rdy && !l_;
        lacc = v_ && rdy && l_;
        com  = c_ && (m_spec.size() > 0) && (m_cmt.size() < 4);
        ret  = s_ && (m_cmt.size() > 0);
        nxt  = m_ld;
        if (m_ld == 0 && lacc) begin
            m_load_addr = a_;
            nxt = m_hit(a_) ? 2 : 1;
        end else if (m_ld == 1 && lm_) begin
            nxt = 0;
        end else if (m_ld == 2 && !m_hit(m_load_addr)) begin
            nxt = 1;
        end
        if (ret) void'(m_cmt.pop_front());
        if (com) m_cmt.push_back(m_spec.pop_front());
        if (push) m_spec.push_back(a_);
        m_ld = nxt;
    endtask

    task automatic cycle(input logic r_, v_, l_, input logic [31:0] a_, input logic c_, s_, lm_);
        rst = r_; valid = v_; is_load = l_; addr = a_; commit = c_; smr = s_; lmr = lm_;
        m_step(r_, v_, l_, a_, c_, s_, lm_);
        exp_q.push_back(m_obs());
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lit(input string nm, input logic e_rdy, e_req, input logic [7:0] e_st, input logic [1:0] e_ld);
        obs_t e, g;
        e = {e_rdy, e_req, e_st, e_ld};
        g = dut_obs();
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got rdy=%b req=%b st=%h ld=%0d, need rdy=%b req=%b st=%h ld=%0d",
                     nm, g.ready, g.req, g.st, g.ld, e.ready, e.req, e.st, e.ld);
        end else begin
            $display("check %s ok: st=%h ld=%0d", nm, g.st, g.ld);
        end
    endtask

    // Monitor: every edge after which an expectation exists, pop and compare.
    initial begin
        obs_t e, g;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = dut_obs();
                n_cmp++;
                n_edge++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL edge%0d outputs: got rdy=%b req=%b st=%h ld=%0d, need rdy=%b req=%b st=%h ld=%0d",
                             n_edge, g.ready, g.req, g.st, g.ld, e.ready, e.req, e.st, e.ld);
                end else begin
                    $display("edge%0d rdy=%b req=%b st=%h ld=%0d", n_edge, g.ready, g.req, g.st, g.ld);
                end
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1; valid = 1'b0; is_load = 1'b0; addr = '0; commit = 1'b0; smr = 1'b0; lmr = 1'b0;
        m_ld = 0; m_load_addr = '0;

        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        lit("reset", 1'b1, 1'b0, 8'h00, 2'd0);

        cycle(1'b0, 1'b1, 1'b0, 32'h1000, 1'b0, 1'b0, 1'b0);
        lit("store_push", 1'b1, 1'b0, 8'h01, 2'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        lit("store_commit", 1'b1, 1'b0, 8'h10, 2'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        lit("store_retire", 1'b1, 1'b0, 8'h00, 2'd0);

        cycle(1'b0, 1'b1, 1'b1, 32'h2000, 1'b0, 1'b0, 1'b0);
        lit("clean_load", 1'b0, 1'b1, 8'h00, 2'd1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        lit("load_resp", 1'b1, 1'b0, 8'h00, 2'd0);

        cycle(1'b0, 1'b1, 1'b0, 32'h1008, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 32'h5008, 1'b0, 1'b0, 1'b0);
        lit("hazard_block", 1'b0, 1'b0, 8'h10, 2'd2);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        lit("hazard_still", 1'b0, 1'b0, 8'h00, 2'd2);
        idle();
        lit("hazard_release", 1'b0, 1'b1, 8'h00, 2'd1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 32'h3000 + 32'(i * 16), 1'b0, 1'b0, 1'b0);
        lit("spec_full", 1'b0, 1'b0, 8'h0F, 2'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        lit("spec_one_commit", 1'b1, 1'b0, 8'h17, 2'd0);

        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 32'h4000, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 32'h4010, 1'b1, 1'b0, 1'b0);
        lit("simul_setup", 1'b1, 1'b0, 8'h11, 2'd0);
        cycle(1'b0, 1'b1, 1'b0, 32'h4020, 1'b1, 1'b1, 1'b0);
        lit("simul_all", 1'b1, 1'b0, 8'h11, 2'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        lit("empty_ignore", 1'b1, 1'b0, 8'h00, 2'd0);

        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 3)) << 3) | 32'($urandom_range(0, 7));
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, a,
                  $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3);
        end
        idle();
        idle();

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #3;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, need 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cva6_lsu_queue_model.md
# cva6_lsu_queue_model

Cycle-level control model of the CVA6 load/store unit: a single-outstanding load FSM plus a two-stage store buffer. The store buffer has a 4-entry speculative queue and a 4-entry commit queue. The block tracks instruction acceptance, store commit/retire and load issue, including the page-offset hazard check of loads against buffered stores. It sits between issue/commit control and the memory interface, and carries no data payload, only addresses.

## Interface
- No parameters. Queue depths are fixed at 4 (speculative) and 4 (commit); the page-offset compare field is address bits [11:3].
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  synchronous reset, active-high (1 = reset); one clock; reset is synchronous and active-high.
- instr_i  in  32  memory address of the offered instruction.
- is_load_i  in  1  1 = load, 0 = store; sampled with instr_valid_i.
- instr_valid_i  in  1  instruction offered; accepted when instr_valid_i && ready_o.
- store_commit_i  in  1  oldest speculative store is committed.
- store_mem_resp_i  in  1  memory completed the oldest committed store.
- load_mem_resp_i  in  1  memory returned the outstanding load.
- load_req_o  out  1  load request to memory is pending.
- ready_o  out  1  unit can accept an instruction this cycle.
- store_state_o  out  8  [3:0] speculative-queue occupancy, [7:4] commit-queue occupancy.
- load_state_o  out  2  load FSM state: 0 IDLE, 1 WAIT_RESP, 2 BLOCKED; 3 is never produced.

## Operation
- Occupancy encoding is thermometer: bit i of a nibble = (count > i). Examples: count 0 = 4'b0000, count 1 = 4'b0001, count 3 = 4'b0111, count 4 = 4'b1111.
- ready_o = (load state == IDLE) && (spec count < 4). It is combinational from registered state only.
- Every decision in a cycle uses the pre-edge state. Counts update as:
  - spec' = spec + push − commit
  - commit' = commit + commit − retire
- **Store accept** (valid && ready && !is_load): push instr_i at the spec-queue tail.
- **Commit:** store_commit_i with spec count > 0 and commit count < 4.
  - Move the spec head address to the commit-queue tail.
  - Otherwise ignore store_commit_i (no state change). A push into an empty spec queue in the same cycle is not committable that cycle.
- **Retire:** store_mem_resp_i with commit count > 0 pops the commit head. Otherwise it is ignored.
- Push, commit and retire may all occur in one cycle; each applies independently per the rules above.
- **Load accept** (valid && ready && is_load): latch instr_i as the load address.
  - If any valid entry in either queue (pre-edge contents) has addr[11:3] == instr_i[11:3], go to BLOCKED.
  - Otherwise go to WAIT_RESP.
- **BLOCKED:** each cycle, re-check the latched address against all valid entries in both queues.
  - When no entry matches, go to WAIT_RESP next cycle.
  - Stores may still commit and retire while a load is BLOCKED. New stores cannot be accepted (ready_o = 0).
- **WAIT_RESP:** load_req_o = 1. On load_mem_resp_i, go to IDLE.
- load_mem_resp_i outside WAIT_RESP is ignored.
- load_req_o = (state == WAIT_RESP).

## Timing
- **Reset:** both queues empty, load FSM IDLE, stored addresses cleared to 0. Outputs in reset: ready_o = 1, load_req_o = 0, store_state_o = 8'h00, load_state_o = 2'd0.
- **Reset mid-operation:** the next cycle is the reset state. All pending stores and any in-flight load are discarded.
- An accepted instruction is visible in the outputs the next cycle:
  - store: store_state_o[0] rises;
  - load: load_state_o becomes 1 or 2, ready_o falls.
- Load latency:
  - unblocked: accept at edge N, load_req_o high from N+1;
  - response at edge M returns to IDLE, ready_o = 1 from M+1 (given spec count < 4).
- Blocked → WAIT_RESP takes one cycle after the last matching entry leaves the queues.
- Commit and retire are each visible one cycle after the input edge.
- Spec queue full (4): ready_o = 0 even when the load FSM is IDLE.
- Commit queue full: store_commit_i is dropped.
- Pointers wrap modulo 4. Count 4 is distinct from count 0.

## Test plan
- **Reset:** assert rst_ni for 2 cycles, release. Required: ready_o = 1, load_req_o = 0, store_state_o = 00, load_state_o = 0.
- **Store lifecycle:**
  - store 0x1000 → store_state_o = 01;
  - commit pulse → 10;
  - store_mem_resp → 00.
- **Clean load:** load 0x2000 with empty buffer.
  - Next cycle: load_state_o = 1, load_req_o = 1, ready_o = 0.
  - After load_mem_resp_i: load_state_o = 0, ready_o = 1.
- **Hazard:** store 0x1008, commit, then load 0x5008 (bits [11:3] match).
  - load_state_o = 2, load_req_o = 0.
  - After store_mem_resp_i: load_state_o = 1 one cycle later, then load_req_o = 1.
- **Full spec queue:** 4 stores without commit → store_state_o = 0F, ready_o = 0. One commit → 17, ready_o = 1.
- **Simultaneous events:** with spec = 1 and commit = 1, same cycle store accept + commit + store_mem_resp → store_state_o = 11. Commit with empty spec and retire with empty commit queue → state unchanged.
